// File: rtl/rgb_to_gray_stream_pkg.sv
// Shared constants and helpers for the RGB888 -> 8-bit luma stream converter.
// Luma: Y = (77*R + 150*G + 29*B + 128) >> 8, evaluated in a 16-bit unsigned sum.
package rgb_to_gray_stream_pkg;

  localparam int SUM_W    = 16;
  localparam int PIPE_LAT = 3;

  localparam logic [SUM_W-1:0] COEF_R = 16'd77;
  localparam logic [SUM_W-1:0] COEF_G = 16'd150;
  localparam logic [SUM_W-1:0] COEF_B = 16'd29;
  localparam logic [SUM_W-1:0] RND    = 16'd128;

  // Weighted channel products held between the multiply and add stages.
  typedef struct packed {
    logic [SUM_W-1:0] r;
    logic [SUM_W-1:0] g;
    logic [SUM_W-1:0] b;
  } prod_t;

  // One channel times its coefficient; 255*150 still fits in SUM_W bits.
  function automatic logic [SUM_W-1:0] scale(input logic [7:0] chan,
                                             input logic [SUM_W-1:0] coef);
    return coef * SUM_W'(chan);
  endfunction

  // Upper byte of the rounded sum is the luma value.
  function automatic logic [7:0] luma_byte(input logic [SUM_W-1:0] sum);
    return 8'(sum >> 8);
  endfunction

endpackage

// File: rtl/rgb_to_gray_stream_pipe_delay.sv
// pipe_delay: reset-to-zero shift register of DEPTH stages, W bits wide.
// Carries the valid bit, last-pixel tag and optional coordinates alongside
// the arithmetic stages so side-band information stays aligned with data.
module pipe_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data
);

  logic [DEPTH-1:0][W-1:0] r_stage;

  // Shift one stage per clock; stage 0 captures the input.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every stage is reset, not just the first, so a reset mid-frame
    // cannot leak a stale valid bit out of the pipe after release.
    if (!rst_n) begin
      r_stage <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage take the old value of
      // its predecessor; blocking ones would collapse the chain into one stage.
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/rgb_to_gray_stream.sv
// rgb_to_gray_stream: raster RGB888 stream to 8-bit luma, fixed latency 3.
//   S1 registers the three weighted products, S2 the rounded sum,
//   S3 the luma byte (loaded only for valid pixels, otherwise held).
// Input-side raster counters tag the last pixel of each frame; the tag rides
// the pipeline and becomes frame_end_o, coincident with that pixel's output.
// Optional build macro RGB2GRAY_COORD_EN adds row_o/col_o, the raster
// position of the pixel currently on grayscale_o.
module rgb_to_gray_stream
  import rgb_to_gray_stream_pkg::*;
#(
  parameter  int IMG_WIDTH  = 9,
  parameter  int IMG_HEIGHT = 9,
  localparam int COL_W      = $clog2(IMG_WIDTH),
  localparam int ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [23:0]      rgb_i,
  input  logic             done_i,
  output logic [7:0]       grayscale_o,
  output logic             done_o,
`ifdef RGB2GRAY_COORD_EN
  output logic             frame_end_o,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o
`else
  output logic             frame_end_o
`endif
);

`ifdef RGB2GRAY_COORD_EN
  localparam int TAG_W = 2 + ROW_W + COL_W;
`else
  localparam int TAG_W = 2;
`endif

  // Input raster position of the pixel presented on rgb_i.
  logic [COL_W-1:0] r_col, w_col_nxt;
  logic [ROW_W-1:0] r_row, w_row_nxt;
  logic             w_last;

  // Arithmetic pipeline.
  prod_t            r_prod;
  logic [SUM_W-1:0] r_sum;
  logic [7:0]       r_gray;
  logic             r_done;
  logic             r_frame_end;

  // Side-band pipeline: {coords (optional), last tag, valid}.
  logic [TAG_W-1:0] w_tag_in;
  logic [TAG_W-1:0] w_tag_s2;
  logic             w_valid_s2;
  logic             w_last_s2;

  assign w_last = done_i
                  && (r_col == COL_W'(IMG_WIDTH - 1))
                  && (r_row == ROW_W'(IMG_HEIGHT - 1));

  // Next raster position: advance on each accepted pixel, wrap col then row.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch forms.
    w_col_nxt = r_col;
    w_row_nxt = r_row;
    if (done_i) begin
      if (r_col == COL_W'(IMG_WIDTH - 1)) begin
        w_col_nxt = '0;
        if (r_row == ROW_W'(IMG_HEIGHT - 1)) begin
          w_row_nxt = '0;
        end else begin
          w_row_nxt = r_row + ROW_W'(1);
        end
      end else begin
        w_col_nxt = r_col + COL_W'(1);
      end
    end
  end

  // Raster counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

`ifdef RGB2GRAY_COORD_EN
  assign w_tag_in = {r_row, r_col, w_last, done_i};
`else
  assign w_tag_in = {w_last, done_i};
`endif

  // Side-band covers S1 and S2; the output register below is the third stage.
  pipe_delay #(
    .W     (TAG_W),
    .DEPTH (PIPE_LAT - 1)
  ) u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_data (w_tag_in),
    .o_data (w_tag_s2)
  );

  assign w_valid_s2 = w_tag_s2[0];
  assign w_last_s2  = w_tag_s2[1];

  // S1: weighted channel products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod <= '0;
    end else begin
      r_prod.r <= scale(rgb_i[23:16], COEF_R);
      r_prod.g <= scale(rgb_i[15:8],  COEF_G);
      r_prod.b <= scale(rgb_i[7:0],   COEF_B);
    end
  end

  // S2: rounded sum; max 65408, so SUM_W bits never overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else begin
      r_sum <= r_prod.r + r_prod.g + r_prod.b + RND;
    end
  end

  // S3: output register; luma loads only for valid pixels and holds across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gray      <= '0;
      r_done      <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      r_done      <= w_valid_s2;
      r_frame_end <= w_last_s2;
      if (w_valid_s2) begin
        r_gray <= luma_byte(r_sum);
      end
    end
  end

`ifdef RGB2GRAY_COORD_EN
  logic [ROW_W-1:0] r_row_o;
  logic [COL_W-1:0] r_col_o;

  // S3 for coordinates: follows the luma load so coords hold when done_o=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_o <= '0;
      r_col_o <= '0;
    end else if (w_valid_s2) begin
      r_row_o <= w_tag_s2[TAG_W-1 -: ROW_W];
      r_col_o <= w_tag_s2[2 +: COL_W];
    end
  end

  assign row_o = r_row_o;
  assign col_o = r_col_o;
`endif

  assign grayscale_o = r_gray;
  assign done_o      = r_done;
  assign frame_end_o = r_frame_end;

endmodule
